// File: rtl/xyz_rr_arbiter.sv
// xyz_rr_arbiter: round-robin arbiter with bounded bursts that merges per-port
// x/y/z beats onto one registered output stream with 1-cycle latency.
module xyz_rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_PORTS-1:0]         req_valid,
  output logic [NUM_PORTS-1:0]         req_ready,
  input  logic [NUM_PORTS*DATA_W-1:0]  req_x,
  input  logic [NUM_PORTS*DATA_W-1:0]  req_y,
  input  logic [NUM_PORTS*DATA_W-1:0]  req_z,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_x,
  output logic [DATA_W-1:0]            out_y,
  output logic [DATA_W-1:0]            out_z,
  output logic [$clog2(NUM_PORTS)-1:0] out_idx
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam logic [IDX_W:0]   NP_W     = (IDX_W+1)'(NUM_PORTS);
  localparam logic [3:0]       MB_W     = 4'(MAX_BURST);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_PORTS-1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [3:0]       cnt_q, cnt_d;

  logic             load_en;
  logic             hit;
  logic             xfer;
  logic [IDX_W-1:0] pick;
  logic [IDX_W:0]   scan;

  logic [DATA_W-1:0] x_arr [NUM_PORTS];
  logic [DATA_W-1:0] y_arr [NUM_PORTS];
  logic [DATA_W-1:0] z_arr [NUM_PORTS];

  logic              vld_p1;
  logic [DATA_W-1:0] x_p1, y_p1, z_p1;
  logic [IDX_W-1:0]  idx_p1;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
    assign x_arr[g] = req_x[g*DATA_W +: DATA_W];
    assign y_arr[g] = req_y[g*DATA_W +: DATA_W];
    assign z_arr[g] = req_z[g*DATA_W +: DATA_W];
  end

  // ---- stage p0: grant selection against the output-stage load enable ----
  assign load_en = !vld_p1 || out_ready;

  always_comb begin
    hit  = 1'b0;
    pick = '0;
    scan = '0;
    if (state_q == BURST) begin
      hit  = req_valid[owner_q];
      pick = owner_q;
    end else begin
      // Rotating search starting just after the previous owner, with wrap.
      for (int k = 1; k <= NUM_PORTS; k++) begin
        scan = {1'b0, last_q} + (IDX_W+1)'(k);
        if (scan >= NP_W) scan = scan - NP_W;
        if (!hit && req_valid[scan[IDX_W-1:0]]) begin
          hit  = 1'b1;
          pick = scan[IDX_W-1:0];
        end
      end
    end
  end

  assign xfer = rst_n && load_en && hit;

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[pick] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          owner_d = pick;
          cnt_d   = 4'd1;
          if (MAX_BURST > 1) state_d = BURST;
          else               last_d  = pick;
        end
      end
      BURST: begin
        if (load_en) begin
          if (xfer) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 == MB_W) begin
              state_d = IDLE;
              last_d  = owner_q;
            end
          end else begin
            state_d = IDLE;
            last_d  = owner_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---- stage p1: registered output beat ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      x_p1   <= '0;
      y_p1   <= '0;
      z_p1   <= '0;
      idx_p1 <= '0;
    end else if (load_en) begin
      vld_p1 <= xfer;
      if (xfer) begin
        x_p1   <= x_arr[pick];
        y_p1   <= y_arr[pick];
        z_p1   <= z_arr[pick];
        idx_p1 <= pick;
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_x     = x_p1;
  assign out_y     = y_p1;
  assign out_z     = z_p1;
  assign out_idx   = idx_p1;

endmodule

// File: tb/tb_xyz_rr_arbiter.sv
// Self-checking bench for xyz_rr_arbiter: behavioural arbitration model checked
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_xyz_rr_arbiter;

  localparam int NP = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NP-1:0]   req_valid;
  logic [NP-1:0]   req_ready;
  logic [NP*DW-1:0] req_x, req_y, req_z;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_x, out_y, out_z;
  logic [1:0]      out_idx;

  logic [DW-1:0] px [NP];
  logic [DW-1:0] py [NP];
  logic [DW-1:0] pz [NP];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NP; g++) begin : g_pack
    assign req_x[g*DW +: DW] = px[g];
    assign req_y[g*DW +: DW] = py[g];
    assign req_z[g*DW +: DW] = pz[g];
  end

  xyz_rr_arbiter #(.NUM_PORTS(NP), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_z     (req_z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_z     (out_z),
    .out_idx   (out_idx)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Behavioural model: who holds the grant, how many beats it has had,
  // and who held it last; the output beat is whatever was accepted last.
  logic          m_vld = 1'b0;
  logic [DW-1:0] m_x = '0, m_y = '0, m_z = '0;
  logic [1:0]    m_idx = '0;
  logic          m_busy = 1'b0;
  logic [1:0]    m_owner = '0;
  logic [1:0]    m_last = 2'd3;
  int            m_beats = 0;
  logic          seen_rst = 1'b0;

  function automatic logic [2:0] m_pick();
    logic [2:0] r;
    logic [1:0] p;
    r = 3'b000;
    if (rst_n && (!m_vld || out_ready)) begin
      if (m_busy) r = {req_valid[m_owner], m_owner};
      else begin
        for (int k = 1; k <= NP; k++) begin
          p = m_last + 2'(k);
          if (!r[2] && req_valid[p]) r = {1'b1, p};
        end
      end
    end
    return r;
  endfunction

  always @(posedge clk) begin : model
    logic [2:0] g;
    logic       ld;
    g  = m_pick();
    ld = !m_vld || out_ready;
    if (!rst_n) begin
      seen_rst <= 1'b1;
      m_vld <= 1'b0; m_x <= '0; m_y <= '0; m_z <= '0; m_idx <= '0;
      m_busy <= 1'b0; m_owner <= '0; m_last <= 2'd3; m_beats <= 0;
    end else begin
      if (ld) begin
        m_vld <= g[2];
        if (g[2]) begin
          m_x <= px[g[1:0]]; m_y <= py[g[1:0]]; m_z <= pz[g[1:0]]; m_idx <= g[1:0];
        end
      end
      if (!m_busy) begin
        if (g[2]) begin
          if (MB > 1) begin
            m_busy <= 1'b1; m_owner <= g[1:0]; m_beats <= 1;
          end else m_last <= g[1:0];
        end
      end else if (ld) begin
        if (g[2] && (m_beats + 1 != MB)) m_beats <= m_beats + 1;
        else begin
          m_busy <= 1'b0;
          m_last <= m_owner;
        end
      end
    end
  end

  logic        hold_prev = 1'b0;
  logic [26:0] prev_bundle = '0;

  always @(negedge clk) begin : compare
    logic [2:0] g;
    logic [3:0] exp_rdy;
    if (seen_rst) begin
      g = m_pick();
      exp_rdy = '0;
      if (g[2]) exp_rdy[g[1:0]] = 1'b1;
      check("model_req_ready", 32'(req_ready), 32'(exp_rdy));
      check("model_out_valid", 32'(out_valid), 32'(m_vld));
      if (m_vld) begin
        check("model_out_idx", 32'(out_idx), 32'(m_idx));
        check("model_out_x", 32'(out_x), 32'(m_x));
        check("model_out_y", 32'(out_y), 32'(m_y));
        check("model_out_z", 32'(out_z), 32'(m_z));
      end
      check("ready_onehot", 32'($countones(req_ready) <= 1), 1);
      check("ready_implies_valid", 32'((req_ready & ~req_valid) == 4'b0), 1);
      if (hold_prev)
        check("stall_stable", 32'({out_valid, out_idx, out_x, out_y, out_z}), 32'(prev_bundle));
      hold_prev   = out_valid && !out_ready && rst_n;
      prev_bundle = {out_valid, out_idx, out_x, out_y, out_z};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic default_fields();
    for (int i = 0; i < NP; i++) begin
      px[i] = 8'(16*i + 1);
      py[i] = 8'(16*i + 2);
      pz[i] = 8'(16*i + 3);
    end
  endtask

  int exp_seq [17] = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0};
  logic [4:0] vec_tab [16] = '{5'b1111_0, 5'b1111_0, 5'b1111_1, 5'b0010_1,
                                5'b0010_0, 5'b1010_1, 5'b1010_1, 5'b0000_1,
                                5'b1001_1, 5'b1001_0, 5'b1001_1, 5'b0100_1,
                                5'b0110_1, 5'b0110_1, 5'b0001_0, 5'b0001_1};

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    req_valid = '1;
    out_ready = 1'b1;
    default_fields();
    tick();
    tick();
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_idx", 32'(out_idx), 0);
    check("rst_out_x", 32'(out_x), 0);

    // Single requester on port 0
    tick();
    rst_n = 1'b1;
    req_valid = 4'b0001;
    @(negedge clk);
    check("p0_req_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    check("p0_out_valid", 32'(out_valid), 1);
    check("p0_out_x", 32'(out_x), 1);
    check("p0_out_y", 32'(out_y), 2);
    check("p0_out_z", 32'(out_z), 3);
    check("p0_out_idx", 32'(out_idx), 0);
    tick();

    // All ports valid: bursts of four rotate 0,1,2,3,0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req_valid = 4'hF;
    for (int k = 0; k < 17; k++) begin
      for (int i = 0; i < NP; i++) begin
        px[i] = 8'($urandom);
        py[i] = 8'($urandom);
        pz[i] = 8'($urandom);
      end
      tick();
      @(negedge clk);
      check("rr_out_valid", 32'(out_valid), 1);
      check("rr_out_idx", 32'(out_idx), 32'(exp_seq[k]));
    end
    default_fields();

    // Backpressure in the middle of a port-1 burst
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req_valid = 4'b0110;
    tick();
    @(negedge clk);
    check("bp_beat1_idx", 32'(out_idx), 1);
    tick();
    out_ready = 1'b0;
    px[1] = 8'hAA;
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      check("bp_stall_ready", 32'(req_ready), 0);
      check("bp_stall_x", 32'(out_x), 17);
      check("bp_stall_idx", 32'(out_idx), 1);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 32'(req_ready), 32'h2);
    tick();
    @(negedge clk);
    check("bp_beat3_idx", 32'(out_idx), 1);
    check("bp_beat3_x", 32'(out_x), 32'hAA);
    tick();
    @(negedge clk);
    check("bp_beat4_idx", 32'(out_idx), 1);
    tick();
    @(negedge clk);
    check("bp_next_idx", 32'(out_idx), 2);
    default_fields();

    // Owner drops mid-burst: pointer moves past it
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req_valid = 4'b0101;
    tick();
    tick();
    req_valid = 4'b0100;
    @(negedge clk);
    check("drop_req_ready", 32'(req_ready), 0);
    tick();
    req_valid = 4'b0101;
    @(negedge clk);
    check("drop_out_valid", 32'(out_valid), 0);
    check("drop_next_ready", 32'(req_ready), 32'h4);
    tick();
    @(negedge clk);
    check("drop_next_idx", 32'(out_idx), 2);

    // Reset during port-3 beat 2
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req_valid = 4'b1000;
    tick();
    tick();
    rst_n = 1'b0;
    req_valid = 4'hF;
    @(negedge clk);
    check("mid_rst_pre_valid", 32'(out_valid), 1);
    check("mid_rst_pre_idx", 32'(out_idx), 3);
    check("mid_rst_ready", 32'(req_ready), 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_first_ready", 32'(req_ready), 32'h1);
    tick();
    @(negedge clk);
    check("mid_rst_first_idx", 32'(out_idx), 0);

    // Mixed valid/ready table, checked by the model every cycle
    for (int v = 0; v < 16; v++) begin
      req_valid = vec_tab[v][4:1];
      out_ready = vec_tab[v][0];
      px[v % NP] = 8'(v * 7 + 5);
      tick();
    end
    req_valid = '0;
    out_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
